// File: rtl/uart_pic_top.sv
// uart_pic_top: UART image download into a grayscale frame buffer, echoed back on TX
// and continuously scanned out as RGB444 video with hsync/vsync/de timing.
module uart_pic_top #(
    parameter int CLKS_PER_BIT = 40,
    parameter int IMG_W        = 360,
    parameter int IMG_H        = 360,
    parameter int H_ACT        = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACT        = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33
) (
    input  logic        sys_clk_p,
    input  logic        rst,
    input  logic        key_c,
    input  logic        uart_rx,
    input  logic        sw8,
    output logic        SCL,
    output logic        SDA,
    output logic        pic_done,
    output logic        wr_ram,
    output logic        rom_ena,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de,
    output logic [11:0] dvi_d,
    output logic        dvi_xclk_p,
    output logic        dvi_xclk_n,
    output logic        rst_b,
    output logic        uart_tx,
    output logic [7:0]  rgb_led,
    output logic        download
);
    localparam int DEPTH = IMG_W * IMG_H;
    localparam int AW    = $clog2(DEPTH);
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    localparam logic [HW-1:0] H_END = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_A   = HW'(H_ACT);
    localparam logic [HW-1:0] HS_B  = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0] HS_E  = HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [HW-1:0] I_W   = HW'(IMG_W);
    localparam logic [VW-1:0] V_END = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_A   = VW'(V_ACT);
    localparam logic [VW-1:0] VS_B  = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0] VS_E  = VW'(V_ACT + V_FP + V_SYNC);
    localparam logic [VW-1:0] I_H   = VW'(IMG_H);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_st_t;

    logic [1:0]    rx_s_q, key_s_q;
    logic          key_prev_q;
    rx_st_t        rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          valid_q, valid_d;
    tx_st_t        tx_st_q, tx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [9:0]    tx_sh_q, tx_sh_d;
    logic [AW-1:0] waddr_q;
    logic          pic_done_q;
    logic [7:0]    rgb_led_q;
    logic [HW-1:0] h_cnt_q;
    logic [VW-1:0] v_cnt_q;
    logic          hsync_q, vsync_q, de_q, img_q;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    rdata_q;
    logic          rx, key_rise, we, img;
    logic [AW-1:0] raddr;

    assign rx       = rx_s_q[1];
    assign key_rise = key_s_q[1] & ~key_prev_q;
    // A restart in the same cycle as a received byte takes priority over the write.
    assign we       = valid_q & sw8 & ~pic_done_q & ~key_rise;
    assign img      = (h_cnt_q < I_W) && (v_cnt_q < I_H);
    assign raddr    = AW'(v_cnt_q * IMG_W + h_cnt_q);

    always_ff @(posedge sys_clk_p or posedge rst) begin
        if (rst) begin
            rx_s_q     <= 2'b11;
            key_s_q    <= 2'b00;
            key_prev_q <= 1'b0;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            valid_q    <= 1'b0;
            tx_st_q    <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '1;
        end else begin
            rx_s_q     <= {rx_s_q[0], uart_rx};
            key_s_q    <= {key_s_q[0], key_c};
            key_prev_q <= key_s_q[1];
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            valid_q    <= valid_d;
            tx_st_q    <= tx_st_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
        end
    end

    // Receiver: bits arrive MSB first, so shifting left leaves the first bit in bit 7.
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q + CW'(1);
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        valid_d  = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx) rx_st_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == FULL) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_sh_q[6:0], rx};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == FULL) begin
                valid_d = rx;
                rx_st_d = RX_IDLE;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // Echo transmitter: frame shifted out of bit 9, refilled with idle ones.
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q + CW'(1);
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        case (tx_st_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                if (valid_q) begin
                    tx_sh_d = {1'b0, rx_sh_q, 1'b1};
                    tx_st_d = TX_BUSY;
                end
            end
            default: if (tx_cnt_q == FULL) begin
                tx_cnt_d = '0;
                tx_sh_d  = {tx_sh_q[8:0], 1'b1};
                tx_bit_d = tx_bit_q + 4'd1;
                if (tx_bit_q == 4'd9) tx_st_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_p or posedge rst) begin
        if (rst) begin
            waddr_q    <= '0;
            pic_done_q <= 1'b0;
            rgb_led_q  <= '0;
        end else begin
            if (valid_q) rgb_led_q <= rx_sh_q;
            if (key_rise) begin
                pic_done_q <= 1'b0;
                waddr_q    <= '0;
            end else if (we) begin
                pic_done_q <= (waddr_q == LAST);
                waddr_q    <= (waddr_q == LAST) ? '0 : waddr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk_p) begin
        if (we) mem[waddr_q] <= rx_sh_q;
        if (img) rdata_q <= mem[raddr];
    end

    // Timing outputs are delayed one stage so they line up with the RAM read data.
    always_ff @(posedge sys_clk_p or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            img_q   <= 1'b0;
        end else begin
            h_cnt_q <= (h_cnt_q == H_END) ? '0 : h_cnt_q + HW'(1);
            if (h_cnt_q == H_END) v_cnt_q <= (v_cnt_q == V_END) ? '0 : v_cnt_q + VW'(1);
            hsync_q <= !((h_cnt_q >= HS_B) && (h_cnt_q < HS_E));
            vsync_q <= !((v_cnt_q >= VS_B) && (v_cnt_q < VS_E));
            de_q    <= (h_cnt_q < H_A) && (v_cnt_q < V_A);
            img_q   <= img;
        end
    end

    assign dvi_d      = img_q ? {3{rdata_q[7:4]}} : 12'd0;
    assign rom_ena    = img_q;
    assign hsync_out  = hsync_q;
    assign vsync_out  = vsync_q;
    assign de         = de_q;
    assign pic_done   = pic_done_q;
    assign wr_ram     = we;
    assign rgb_led    = rgb_led_q;
    assign uart_tx    = tx_sh_q[9];
    assign download   = sw8 & ~pic_done_q;
    assign SCL        = 1'b1;
    assign SDA        = 1'b1;
    assign dvi_xclk_p = sys_clk_p;
    assign dvi_xclk_n = ~sys_clk_p;
    assign rst_b      = ~rst;
endmodule

// File: tb/tb_uart_pic_top.sv
// tb_uart_pic_top: directed bench for uart_pic_top using a scaled-down image, video
// timing and bit period so complete downloads and frames fit in a short run.
module tb_uart_pic_top;
    localparam int CPB = 8;
    localparam int IW = 6, IH = 4;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 8, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int DEPTH = IW * IH;
    localparam int BIT_NS = CPB * 10;

    logic        clk = 1'b0, rst = 1'b1, key_c = 1'b0, uart_rx = 1'b1, sw8 = 1'b0;
    logic        SCL, SDA, pic_done, wr_ram, rom_ena, hsync_out, vsync_out, de;
    logic [11:0] dvi_d;
    logic        dvi_xclk_p, dvi_xclk_n, rst_b, uart_tx, download;
    logic [7:0]  rgb_led;

    int          checks = 0, errors = 0;
    int          wr_cnt = 0, echo_cnt = 0;
    logic [7:0]  echo_byte = 8'h00;
    logic [7:0]  exp_mem [DEPTH];
    logic [11:0] pix [IH][IW+1];

    uart_pic_top #(
        .CLKS_PER_BIT(CPB), .IMG_W(IW), .IMG_H(IH),
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .sys_clk_p(clk), .rst(rst), .key_c(key_c), .uart_rx(uart_rx), .sw8(sw8),
        .SCL(SCL), .SDA(SDA), .pic_done(pic_done), .wr_ram(wr_ram), .rom_ena(rom_ena),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .de(de), .dvi_d(dvi_d),
        .dvi_xclk_p(dvi_xclk_p), .dvi_xclk_n(dvi_xclk_n), .rst_b(rst_b),
        .uart_tx(uart_tx), .rgb_led(rgb_led), .download(download)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_ram === 1'b1) wr_cnt++;

    // Independent UART receiver watching the echo line.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            #(BIT_NS / 2);
            if (uart_tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    #(BIT_NS);
                    b = {b[6:0], uart_tx};
                end
                #(BIT_NS);
                if (uart_tx === 1'b1) begin
                    echo_byte = b;
                    echo_cnt++;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {1'b0, b, stop};
        for (int i = 9; i >= 0; i--) begin
            uart_rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic capture_frame();
        int n;
        n = 0;
        while (vsync_out !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        while (vsync_out !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        for (int y = 0; y < IH; y++) begin
            while (de !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
            for (int x = 0; x <= IW; x++) begin
                pix[y][x] = dvi_d;
                @(negedge clk);
            end
            while (de !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL frame_capture timeout: waited %0d cycles, limit 3000", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({uart_tx, hsync_out, vsync_out, de, pic_done, rst_b, wr_ram, rom_ena} !== 8'b1110_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got tx,hs,vs,de,done,rst_b,wr,rom=%b required 11100000",
                     {uart_tx, hsync_out, vsync_out, de, pic_done, rst_b, wr_ram, rom_ena});
        end
        checks++;
        if (rgb_led !== 8'h00 || dvi_d !== 12'h000) begin
            errors++;
            $display("FAIL reset_data: rgb_led=%h dvi_d=%h required 00 000", rgb_led, dvi_d);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rst_b, SCL, SDA, dvi_xclk_p, dvi_xclk_n} !== 5'b11101) begin
            errors++;
            $display("FAIL post_reset_pins: rst_b,scl,sda,xclk_p,xclk_n=%b required 11101",
                     {rst_b, SCL, SDA, dvi_xclk_p, dvi_xclk_n});
        end
    endtask

    task automatic test_single_byte();
        int w0, e0;
        sw8 = 1'b1;
        @(negedge clk);
        w0 = wr_cnt;
        e0 = echo_cnt;
        send_byte(8'hA5, 1'b1);
        exp_mem[0] = 8'hA5;
        idle_bits(1);
        checks++;
        if (rgb_led !== 8'hA5) begin
            errors++;
            $display("FAIL single_rgb_led: got %h required a5", rgb_led);
        end
        checks++;
        if (wr_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL single_wr_ram: got %0d pulses required 1", wr_cnt - w0);
        end
        checks++;
        if (download !== 1'b1 || pic_done !== 1'b0) begin
            errors++;
            $display("FAIL single_status: download=%b pic_done=%b required 1 0", download, pic_done);
        end
        idle_bits(12);
        checks++;
        if (echo_cnt - e0 !== 1 || echo_byte !== 8'hA5) begin
            errors++;
            $display("FAIL single_echo: got %0d frames last %h required 1 frame a5", echo_cnt - e0, echo_byte);
        end
        capture_frame();
        checks++;
        if (pix[0][0] !== 12'hAAA) begin
            errors++;
            $display("FAIL single_pixel00: got %h required aaa", pix[0][0]);
        end
        checks++;
        if (pix[0][IW] !== 12'h000) begin
            errors++;
            $display("FAIL active_outside_image: got %h required 000", pix[0][IW]);
        end
    endtask

    task automatic test_framing_error();
        int w0;
        w0 = wr_cnt;
        send_byte(8'h3C, 1'b0);
        idle_bits(3);
        checks++;
        if (wr_cnt - w0 !== 0 || rgb_led !== 8'hA5) begin
            errors++;
            $display("FAIL framing_error: wr pulses %0d rgb_led %h required 0 a5", wr_cnt - w0, rgb_led);
        end
    endtask

    task automatic test_sw8_off();
        int w0;
        sw8 = 1'b0;
        @(negedge clk);
        w0 = wr_cnt;
        checks++;
        if (download !== 1'b0) begin
            errors++;
            $display("FAIL sw8_off_download: got %b required 0", download);
        end
        send_byte(8'h12, 1'b1);
        idle_bits(1);
        checks++;
        if (rgb_led !== 8'h12 || wr_cnt - w0 !== 0) begin
            errors++;
            $display("FAIL sw8_off: rgb_led %h wr pulses %0d required 12 0", rgb_led, wr_cnt - w0);
        end
        sw8 = 1'b1;
    endtask

    // Fills addresses 1..DEPTH-1 with back-to-back frames (no idle between bytes).
    task automatic test_fill_back_to_back();
        int w0;
        logic [7:0] d;
        @(negedge clk);
        w0 = wr_cnt;
        for (int i = 1; i < DEPTH; i++) begin
            d = 8'(i * 37 + 16);
            exp_mem[i] = d;
            if (i == DEPTH - 1) begin
                checks++;
                if (pic_done !== 1'b0) begin
                    errors++;
                    $display("FAIL done_early: pic_done=%b before last byte required 0", pic_done);
                end
            end
            send_byte(d, 1'b1);
        end
        idle_bits(1);
        checks++;
        if (wr_cnt - w0 !== DEPTH - 1) begin
            errors++;
            $display("FAIL fill_writes: got %0d pulses required %0d", wr_cnt - w0, DEPTH - 1);
        end
        checks++;
        if (pic_done !== 1'b1 || download !== 1'b0) begin
            errors++;
            $display("FAIL fill_done: pic_done=%b download=%b required 1 0", pic_done, download);
        end
        w0 = wr_cnt;
        send_byte(8'hE7, 1'b1);
        idle_bits(1);
        checks++;
        if (wr_cnt - w0 !== 0 || rgb_led !== 8'hE7 || pic_done !== 1'b1) begin
            errors++;
            $display("FAIL extra_byte: wr pulses %0d rgb_led %h done %b required 0 e7 1",
                     wr_cnt - w0, rgb_led, pic_done);
        end
        capture_frame();
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++) begin
                d = exp_mem[y * IW + x];
                checks++;
                if (pix[y][x] !== {d[7:4], d[7:4], d[7:4]}) begin
                    errors++;
                    $display("FAIL image_pixel(%0d,%0d): got %h required %h", x, y, pix[y][x], {d[7:4], d[7:4], d[7:4]});
                end
            end
    endtask

    task automatic test_restart();
        int w0;
        logic [7:0] d;
        key_c = 1'b1;
        repeat (3) @(negedge clk);
        key_c = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (pic_done !== 1'b0 || download !== 1'b1) begin
            errors++;
            $display("FAIL restart_status: pic_done=%b download=%b required 0 1", pic_done, download);
        end
        w0 = wr_cnt;
        send_byte(8'h5F, 1'b1);
        exp_mem[0] = 8'h5F;
        idle_bits(1);
        checks++;
        if (wr_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL restart_write: got %0d pulses required 1", wr_cnt - w0);
        end
        capture_frame();
        checks++;
        if (pix[0][0] !== 12'h555) begin
            errors++;
            $display("FAIL restart_pixel00: got %h required 555", pix[0][0]);
        end
        d = exp_mem[1];
        checks++;
        if (pix[0][1] !== {d[7:4], d[7:4], d[7:4]}) begin
            errors++;
            $display("FAIL restart_pixel10: got %h required %h", pix[0][1], {d[7:4], d[7:4], d[7:4]});
        end
    endtask

    task automatic test_timing();
        int hs_lo, vs_lo, de_hi, rom_hi, blank_bad, run, n;
        hs_lo = 0; vs_lo = 0; de_hi = 0; rom_hi = 0; blank_bad = 0;
        for (int i = 0; i < HT * VT; i++) begin
            @(negedge clk);
            if (hsync_out === 1'b0) hs_lo++;
            if (vsync_out === 1'b0) vs_lo++;
            if (de === 1'b1) de_hi++;
            if (rom_ena === 1'b1) rom_hi++;
            if (de !== 1'b1 && dvi_d !== 12'h000) blank_bad++;
        end
        checks++;
        if (hs_lo !== HS * VT) begin
            errors++;
            $display("FAIL hsync_low_per_frame: got %0d required %0d", hs_lo, HS * VT);
        end
        checks++;
        if (vs_lo !== VS * HT) begin
            errors++;
            $display("FAIL vsync_low_per_frame: got %0d required %0d", vs_lo, VS * HT);
        end
        checks++;
        if (de_hi !== HA * VA) begin
            errors++;
            $display("FAIL de_per_frame: got %0d required %0d", de_hi, HA * VA);
        end
        checks++;
        if (rom_hi !== IW * IH) begin
            errors++;
            $display("FAIL rom_ena_per_frame: got %0d required %0d", rom_hi, IW * IH);
        end
        checks++;
        if (blank_bad !== 0) begin
            errors++;
            $display("FAIL blank_dvi_d: got %0d nonzero blanking samples required 0", blank_bad);
        end
        n = 0;
        while (hsync_out !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        while (hsync_out !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        run = 0;
        while (hsync_out === 1'b0 && n < 100) begin @(negedge clk); n++; run++; end
        checks++;
        if (run !== HS || n >= 100) begin
            errors++;
            $display("FAIL hsync_pulse_width: got %0d clocks required %0d", run, HS);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_framing_error();
        test_sw8_off();
        test_fill_back_to_back();
        test_restart();
        test_timing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
